// File: rtl/mov_pkg.sv
// Shared definitions for the pipelined move unit: mode encodings and the
// mode-to-function helpers used by the datapath.
package mov_pkg;

    localparam logic [1:0] MODE_MOV   = 2'b00;
    localparam logic [1:0] MODE_MVN   = 2'b01;
    localparam logic [1:0] MODE_MOVZ  = 2'b10;
    localparam logic [1:0] MODE_MOVNZ = 2'b11;

    // Helpers work on the mode and a zero flag only, so they stay width-agnostic.
    function automatic logic mode_inverts(input logic [1:0] mode);
        return (mode == MODE_MVN);
    endfunction

    function automatic logic mode_wen(input logic [1:0] mode, input logic cond_zero);
        logic wen;
        case (mode)
            MODE_MOVZ:  wen = cond_zero;
            MODE_MOVNZ: wen = !cond_zero;
            default:    wen = 1'b1;
        endcase
        return wen;
    endfunction

endpackage

// File: rtl/mov_pipe_nbit_stage.sv
// One pipeline register slice: valid, data and write-enable, with the
// skid-free ready-chain load rule (an empty slice always loads).
module mov_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_wen,
    input  logic             ready_next,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             wen
);

    logic load;

    assign load = !valid || ready_next;

    // Payload only changes on a valid load so out1 does not drift between beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            wen   <= 1'b0;
        end else if (load) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
                wen  <= up_wen;
            end
        end
    end

endmodule

// File: rtl/mov_pipe_nbit.sv
// Pipelined N-bit move unit: mode function ahead of STAGES register slices,
// valid/ready on both sides, and a counter of accepted operations.
module mov_pipe_nbit
    import mov_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out1,
    output logic             out_wen,
    output logic [CNT_W-1:0] op_count
);

    if ((STAGES < 1) || (STAGES > 8)) begin : g_bad_stages
        $error("mov_pipe_nbit: STAGES must be in 1..8");
    end

    logic [WIDTH-1:0]  op_data;
    logic              op_wen;
    logic              accept;
    logic [STAGES-1:0] stg_valid;
    logic [STAGES-1:0] stg_wen;
    logic [WIDTH-1:0]  stg_data [STAGES];
    logic [STAGES-1:0] ready;

    assign op_data = mode_inverts(mode) ? ~in1 : in1;
    assign op_wen  = mode_wen(mode, in2 == '0);

    // Ready chain resolved back-to-front in one process to keep it acyclic.
    always_comb begin
        ready = '0;
        ready[STAGES-1] = out_ready;
        for (int unsigned k = STAGES - 1; k > 0; k--) begin
            ready[k-1] = !stg_valid[k] || ready[k];
        end
    end

    assign in_ready = !stg_valid[0] || ready[0];
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             up_wen;

        if (k == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = op_data;
            assign up_wen   = op_wen;
        end else begin : g_body
            assign up_valid = stg_valid[k-1];
            assign up_data  = stg_data[k-1];
            assign up_wen   = stg_wen[k-1];
        end

        mov_stage #(.WIDTH(WIDTH)) u_stage (
            .clk        (clk),
            .rst        (rst),
            .up_valid   (up_valid),
            .up_data    (up_data),
            .up_wen     (up_wen),
            .ready_next (ready[k]),
            .valid      (stg_valid[k]),
            .data       (stg_data[k]),
            .wen        (stg_wen[k])
        );
    end

    assign out_valid = stg_valid[STAGES-1];
    assign out1      = stg_data[STAGES-1];
    assign out_wen   = stg_wen[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (accept) begin
            op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_mov_pipe_nbit.sv
// Self-checking bench for mov_pipe_nbit: directed scenarios plus a randomized
// stream, all checked against an ordered-queue reference model.
module tb_mov_pipe_nbit;
    import mov_pkg::*;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int CNT_W  = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out1;
    logic             out_wen;
    logic [CNT_W-1:0] op_count;

    always #5 clk = ~clk;

    mov_pipe_nbit #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .in1       (in1),
        .in2       (in2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out1      (out1),
        .out_wen   (out_wen),
        .op_count  (op_count)
    );

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             w;
        int               t;
    } item_t;

    item_t            q[$];
    logic [CNT_W-1:0] cnt_m;
    int               edge_n;
    int               last_leave;
    int               n_checks;
    int               n_fail;

    function automatic item_t ref_op(logic [1:0] m, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, int t);
        item_t it;
        it.t = t;
        it.d = (m == 2'b01) ? ~a : a;
        if (m == 2'b10)      it.w = (b == 0);
        else if (m == 2'b11) it.w = (b != 0);
        else                 it.w = 1'b1;
        return it;
    endfunction

    // Front result is visible once it has had STAGES-1 edges to travel and its
    // predecessor has left.
    function automatic bit exp_ov();
        int arrive;
        if (q.size() == 0) return 1'b0;
        arrive = q[0].t + STAGES - 1;
        if (last_leave > arrive) arrive = last_leave;
        return arrive <= edge_n;
    endfunction

    task automatic tick();
        bit ov, ir, acc, pop;
        @(negedge clk);
        ov = exp_ov();
        ir = (q.size() < STAGES) || (out_ready && ov);
        n_checks++;
        if (out_valid !== ov) begin n_fail++; $display("FAIL sb_out_valid: got %b expected %b edge %0d", out_valid, ov, edge_n); end
        if (ov) begin
            n_checks += 2;
            if (out1 !== q[0].d) begin n_fail++; $display("FAIL sb_out1: got %h expected %h edge %0d", out1, q[0].d, edge_n); end
            if (out_wen !== q[0].w) begin n_fail++; $display("FAIL sb_out_wen: got %b expected %b edge %0d", out_wen, q[0].w, edge_n); end
        end
        n_checks += 2;
        if (in_ready !== ir) begin n_fail++; $display("FAIL sb_in_ready: got %b expected %b edge %0d", in_ready, ir, edge_n); end
        if (op_count !== cnt_m) begin n_fail++; $display("FAIL sb_op_count: got %h expected %h edge %0d", op_count, cnt_m, edge_n); end
        acc = in_valid && ir && !rst;
        pop = ov && out_ready;
        @(posedge clk);
        edge_n++;
        if (rst) begin
            q.delete();
            cnt_m = '0;
            last_leave = edge_n;
        end else begin
            if (pop) begin
                void'(q.pop_front());
                last_leave = edge_n;
            end
            if (acc) begin
                q.push_back(ref_op(mode, in1, in2, edge_n));
                cnt_m++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in1 = 32'h1234_5678;
        tick();
        n_checks += 5;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (out1 !== '0) begin n_fail++; $display("FAIL reset_out1: got %h expected 0", out1); end
        if (out_wen !== 1'b0) begin n_fail++; $display("FAIL reset_out_wen: got %b expected 0", out_wen); end
        if (op_count !== '0) begin n_fail++; $display("FAIL reset_op_count: got %h expected 0", op_count); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        rst = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    task automatic test_mov_stream();
        out_ready = 1'b1; in_valid = 1'b1; mode = MODE_MOV; in2 = $urandom;
        in1 = 32'hDEAD_BEEF; tick();
        in1 = 32'h0000_0001; tick();
        n_checks += 3;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mov_a_valid: got %b expected 1", out_valid); end
        if (out1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mov_a: got %h expected deadbeef", out1); end
        if (out_wen !== 1'b1) begin n_fail++; $display("FAIL mov_a_wen: got %b expected 1", out_wen); end
        in1 = 32'hFFFF_FFFF; tick();
        n_checks += 2;
        if (out1 !== 32'h0000_0001) begin n_fail++; $display("FAIL mov_b: got %h expected 00000001", out1); end
        if (out_wen !== 1'b1) begin n_fail++; $display("FAIL mov_b_wen: got %b expected 1", out_wen); end
        in_valid = 1'b0; tick();
        n_checks += 3;
        if (out1 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mov_c: got %h expected ffffffff", out1); end
        if (out_wen !== 1'b1) begin n_fail++; $display("FAIL mov_c_wen: got %b expected 1", out_wen); end
        if (op_count !== 16'd3) begin n_fail++; $display("FAIL mov_op_count: got %0d expected 3", op_count); end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mov_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_mvn();
        out_ready = 1'b1; in_valid = 1'b1; mode = MODE_MVN; in1 = 32'h0F0F_0000; in2 = $urandom;
        tick();
        in_valid = 1'b0; tick();
        n_checks += 3;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mvn_valid: got %b expected 1", out_valid); end
        if (out1 !== 32'hF0F0_FFFF) begin n_fail++; $display("FAIL mvn_out1: got %h expected f0f0ffff", out1); end
        if (out_wen !== 1'b1) begin n_fail++; $display("FAIL mvn_wen: got %b expected 1", out_wen); end
        tick();
    endtask

    task automatic test_cond_moves();
        logic [1:0]       cm [4];
        logic [WIDTH-1:0] c2 [4];
        logic             cw [4];
        logic [WIDTH-1:0] a;
        cm = '{MODE_MOVZ, MODE_MOVZ, MODE_MOVNZ, MODE_MOVNZ};
        c2 = '{32'h0, 32'h5, 32'h8000_0000, 32'h0};
        cw = '{1'b1, 1'b0, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            in_valid = 1'b1; mode = cm[i]; in1 = a; in2 = c2[i];
            tick();
            in_valid = 1'b0; tick();
            n_checks += 3;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL cond%0d_valid: got %b expected 1", i, out_valid); end
            if (out1 !== a) begin n_fail++; $display("FAIL cond%0d_out1: got %h expected %h", i, out1, a); end
            if (out_wen !== cw[i]) begin n_fail++; $display("FAIL cond%0d_wen: got %b expected %b", i, out_wen, cw[i]); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] x, y, z;
        logic [CNT_W-1:0] base;
        x = $urandom; y = $urandom; z = $urandom; base = cnt_m;
        out_ready = 1'b0; in_valid = 1'b1; mode = MODE_MOV;
        in1 = x; tick();
        in1 = y; tick();
        in1 = z;
        n_checks += 2;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full: got %b expected 0", in_ready); end
        if (out1 !== x) begin n_fail++; $display("FAIL bp_hold0: got %h expected %h", out1, x); end
        tick(); tick();
        n_checks += 3;
        if (out1 !== x) begin n_fail++; $display("FAIL bp_hold2: got %h expected %h", out1, x); end
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
        if (op_count !== base + 16'd2) begin n_fail++; $display("FAIL bp_count_stall: got %h expected %h", op_count, base + 16'd2); end
        out_ready = 1'b1; #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_comb: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out1 !== y) begin n_fail++; $display("FAIL bp_drain_y: got %h expected %h", out1, y); end
        tick();
        n_checks++;
        if (out1 !== z) begin n_fail++; $display("FAIL bp_drain_z: got %h expected %h", out1, z); end
        tick();
        n_checks += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
        if (op_count !== base + 16'd3) begin n_fail++; $display("FAIL bp_count: got %h expected %h", op_count, base + 16'd3); end
    endtask

    task automatic test_full_push_pop();
        logic [WIDTH-1:0] a, b, c;
        a = $urandom; b = $urandom; c = $urandom;
        out_ready = 1'b0; in_valid = 1'b1; mode = MODE_MOV;
        in1 = a; tick();
        in1 = b; tick();
        out_ready = 1'b1; in1 = c; #1;
        n_checks += 3;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fpp_in_ready: got %b expected 1", in_ready); end
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fpp_valid: got %b expected 1", out_valid); end
        if (out1 !== a) begin n_fail++; $display("FAIL fpp_out_a: got %h expected %h", out1, a); end
        tick();
        out_ready = 1'b0; in_valid = 1'b0; #1;
        n_checks += 3;
        if (out1 !== b) begin n_fail++; $display("FAIL fpp_out_b: got %h expected %h", out1, b); end
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fpp_valid_after: got %b expected 1", out_valid); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fpp_still_full: got %b expected 0", in_ready); end
        out_ready = 1'b1;
        tick(); tick(); tick();
    endtask

    task automatic test_reset_midflight();
        logic [WIDTH-1:0] r;
        r = $urandom;
        out_ready = 1'b0; in_valid = 1'b1; mode = MODE_MOV;
        in1 = $urandom; tick();
        in1 = $urandom; tick();
        rst = 1'b1; in1 = $urandom; tick();
        rst = 1'b0; in_valid = 1'b0;
        n_checks += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_valid: got %b expected 0", out_valid); end
        if (op_count !== '0) begin n_fail++; $display("FAIL rmf_count: got %h expected 0", op_count); end
        out_ready = 1'b1; in_valid = 1'b1; in1 = r; tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmf_early: got %b expected 0", out_valid); end
        tick();
        n_checks += 3;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmf_post_valid: got %b expected 1", out_valid); end
        if (out1 !== r) begin n_fail++; $display("FAIL rmf_post_out1: got %h expected %h", out1, r); end
        if (op_count !== 16'd1) begin n_fail++; $display("FAIL rmf_post_count: got %h expected 1", op_count); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 149) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            mode      = 2'($urandom_range(0, 3));
            in1       = $urandom;
            in2       = ($urandom_range(0, 1) == 0) ? '0 : $urandom;
            tick();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < STAGES + 2; i++) tick();
    endtask

    task automatic test_count_wrap();
        rst = 1'b1; tick();
        rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            mode = 2'($urandom_range(0, 3));
            in1 = $urandom;
            in2 = $urandom;
            tick();
        end
        n_checks++;
        if (op_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_full: got %h expected ffff", op_count); end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (op_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h expected 0000", op_count); end
        tick(); tick(); tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_fail = 0; edge_n = 0; last_leave = 0; cnt_m = '0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = MODE_MOV; in1 = '0; in2 = '0;
        @(posedge clk); #1;
        test_reset();
        test_mov_stream();
        test_mvn();
        test_cond_moves();
        test_backpressure();
        test_full_push_pop();
        test_reset_midflight();
        test_random();
        test_count_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
